// File: rtl/gray_cntr_seq.sv
// -----------------------------------------------------------------------------
// gray_cntr_seq
//   Run sequencer for an external width-bit Gray code counter. A start request
//   loads a programmed Gray start value into the counter. The sequencer then
//   issues exactly run_len count enables, where a run_len of 0 means 2^width.
//   Pause holds counting in RUN. Abort clears the counter through a one-cycle
//   synchronous init pulse.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   run request, sampled only in IDLE
//   abort        in   abort request, honoured in any state
//   pause        in   hold counting while high (RUN only)
//   start_val    in   Gray start value, captured with start
//   run_len      in   number of count steps (0 -> 2^width)
//   cntr_count   in   Gray count fed back from the counter
//   cntr_init_n  out  synchronous clear to counter, active low
//   cntr_load_n  out  load strobe to counter, active low
//   cntr_data    out  load value to counter
//   cntr_cen     out  count enable to counter
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse, run completed
//   aborted      out  one-cycle pulse, run aborted
//   wrap         out  one-cycle pulse, counter stepped from its top code to 0
// -----------------------------------------------------------------------------
module gray_cntr_seq #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [width-1:0] start_val,
  input  logic [width-1:0] run_len,
  input  logic [width-1:0] cntr_count,
  output logic             cntr_init_n,
  output logic             cntr_load_n,
  output logic [width-1:0] cntr_data,
  output logic             cntr_cen,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ABRT = 3'd4
  } state_e;

  // Gray code of 2^width-1. The counter's next step from this code is back to 0.
  localparam logic [width-1:0] GRAY_TOP = {1'b1, {(width-1){1'b0}}};
  // A run_len of 0 encodes a full lap of 2^width steps.
  localparam logic [width:0]   FULL_RUN = {1'b1, {width{1'b0}}};
  localparam logic [width:0]   REM_ONE  = {{width{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [width-1:0] sv_q,    sv_d;
  logic [width:0]   rem_q,   rem_d;
  logic             wrap_q,  wrap_d;
  logic             cen;

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sv_q    <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sv_d    = sv_q;
    rem_d   = rem_q;

    // Abort suppresses the enable combinationally. An abort in the final RUN
    // cycle therefore wins over completing the run.
    cen = (state_q == RUN) && !pause && !abort;

    unique case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = ABRT;
        end else if (start) begin
          sv_d    = start_val;
          rem_d   = (run_len == '0) ? FULL_RUN : {1'b0, run_len};
          state_d = LOAD;
        end
      end

      LOAD: begin
        state_d = abort ? ABRT : RUN;
      end

      RUN: begin
        if (abort) begin
          state_d = ABRT;
        end else if (cen) begin
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DONE;
          end
        end
      end

      DONE: state_d = IDLE;
      ABRT: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Wrap is flagged one cycle after an enabled step taken from the top code.
  // A load of 0 passes through the load strobe, not through cen, so it cannot
  // raise wrap.
  always_comb begin
    wrap_d = cen && (cntr_count == GRAY_TOP);
  end

  // ---------------------------------------------------------------------------
  // Moore outputs (cntr_cen is the only Mealy term)
  // ---------------------------------------------------------------------------
  assign cntr_init_n = (state_q != ABRT);
  assign cntr_load_n = (state_q != LOAD);
  assign cntr_data   = sv_q;
  assign cntr_cen    = cen;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign aborted     = (state_q == ABRT);
  assign wrap        = wrap_q;

endmodule
